mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WORD_SIZE, default 16, data/address width.
REQ-002 Parameter: LATENCY, default 2, memory access cycles per transfer; legal range 1..8.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-high reset (asserted when 1).
REQ-005 i_req  input  1  instruction-fetch read request, held until i_ready.
REQ-006 i_addr  input  WORD_SIZE  fetch address, stable while i_req high.
REQ-007 i_data  output  WORD_SIZE  fetched word, valid when i_ready high.
REQ-008 i_ready  output  1  one-cycle fetch completion pulse.
REQ-009 d_read  input  1  data read request, held until d_ready.
REQ-010 d_write  input  1  data write request, held until d_ready.
REQ-011 d_addr  input  WORD_SIZE  data address.
REQ-012 d_wdata  input  WORD_SIZE  write data.
REQ-013 d_rdata  output  WORD_SIZE  read data, valid when d_ready high.
REQ-014 d_ready  output  1  one-cycle data completion pulse, for reads and writes.
REQ-015 mem_read  output  1  shared memory read strobe.
REQ-016 mem_write  output  1  shared memory write strobe.
REQ-017 mem_addr  output  WORD_SIZE  shared memory address.
REQ-018 mem_wdata  output  WORD_SIZE  shared memory write data.
REQ-019 mem_rdata  input  WORD_SIZE  memory read data, valid in last access cycle.
REQ-020 busy  output  1  high while an access is in progress.

Function
REQ-021 FSM states IDLE, I_ACC, D_ACC; busy = (state != IDLE).
REQ-022 In IDLE, pending requests are sampled; the grant takes effect at the next edge, which loads cnt = LATENCY-1 and latches the address, write data and direction.
REQ-023 Arbitration: D wins over I, except when last_grant = D and i_req is pending, in which case I wins. No port is starved under continuous requests.
REQ-024 The port whose ready is high in the current cycle has its request ignored, so a held request is not regranted.
REQ-025 In I_ACC and D_ACC, mem_read/mem_write, mem_addr and mem_wdata are driven from the latched values for exactly LATENCY cycles. In IDLE all mem_* outputs are 0.
REQ-026 cnt decrements each access cycle. At cnt == 0 the next edge returns to IDLE and pulses ready for exactly one cycle; for reads it also captures mem_rdata into i_data or d_rdata.
REQ-027 Request-to-ready latency = LATENCY+1 cycles from the first IDLE cycle with the request. The minimum spacing between grants is LATENCY+1 cycles.
REQ-028 If d_read and d_write are both high, a write is performed and the read is ignored.
REQ-029 mem_read and mem_write are never high together.
REQ-030 i_data and d_rdata hold their last captured value between reads. A write does not change d_rdata.
REQ-031 Dropping a request mid-access does not abort it: the access completes and the ready pulse is still issued.
REQ-032 Input changes during an access have no effect on the mem_* outputs.
REQ-033 All outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-034 While reset_n = 1, state returns to IDLE immediately and cnt = 0. All outputs are 0: i_data, d_rdata, i_ready, d_ready, mem_*, busy.
REQ-035 Reset sets last_grant = I.
REQ-036 Reset mid-access abandons the access without any ready pulse. The first grant after reset release uses the rules of REQ-022/REQ-023.

Verification (LATENCY = 2)
REQ-037 i_req with i_addr = 0x0010 in cycle 0, mem_rdata = 0x1234 -> mem_read = 1 with mem_addr = 0x0010 in cycles 1-2; i_ready = 1 and i_data = 0x1234 in cycle 3 only.
REQ-038 i_req and d_read asserted together in cycle 0 -> D access in cycles 1-2, d_ready in cycle 3; I access in cycles 4-5, i_ready in cycle 6.
REQ-039 i_req and d_read held continuously -> grant sequence D, I, D, I; every ready pulse is one cycle wide; no duplicate grant on a ready cycle.
REQ-040 d_write with d_addr = 0x0020, d_wdata = 0xBEEF -> mem_write = 1 with that addr/data stable for 2 cycles; d_ready pulses once; d_rdata unchanged.
REQ-041 reset_n pulsed high during cycle 1 of an I_ACC -> all outputs go to 0 in the same cycle; no i_ready afterwards; a held i_req is regranted after release.
REQ-042 d_read and d_write both high -> only mem_write is asserted; mem_read stays 0 throughout.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter_if                                         |
// | Description : Client (fetch/data) and shared-memory signal bundle    |
// |               for mem_arbiter.                                       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface mem_arbiter_if #(
   parameter int WORD_SIZE = 16
) ();
   // instruction-fetch client
   logic                 i_req;
   logic [WORD_SIZE-1:0] i_addr;
   logic [WORD_SIZE-1:0] i_data;
   logic                 i_ready;
   // data client
   logic                 d_read;
   logic                 d_write;
   logic [WORD_SIZE-1:0] d_addr;
   logic [WORD_SIZE-1:0] d_wdata;
   logic [WORD_SIZE-1:0] d_rdata;
   logic                 d_ready;
   // shared memory
   logic                 mem_read;
   logic                 mem_write;
   logic [WORD_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [WORD_SIZE-1:0] mem_rdata;
   // status
   logic                 busy;

   // Environment side: drives the requests and the memory read data.
   modport master (
      output i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
      input  i_data, i_ready, d_rdata, d_ready,
             mem_read, mem_write, mem_addr, mem_wdata, busy
   );

   // Arbiter side.
   modport slave (
      input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
      output i_data, i_ready, d_rdata, d_ready,
             mem_read, mem_write, mem_addr, mem_wdata, busy
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter                                            |
// | Description : Two-port (fetch / data) arbiter onto a single memory   |
// |               with a fixed access latency and alternating priority.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mem_arbiter #(
   parameter int WORD_SIZE = 16,
   parameter int LATENCY   = 2     // access cycles per transfer, 1..8
) (
   input  wire logic     clk,
   input  wire logic     reset_n,  // active-high, asynchronous
   mem_arbiter_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_I_ACC = 2'd1;
   localparam logic [1:0] S_D_ACC = 2'd2;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   logic [1:0]           state_q,   state_d;
   logic [3:0]           cnt_q,     cnt_d;
   logic                 last_d_q,  last_d_d;   // 1: last grant went to D
   logic [WORD_SIZE-1:0] addr_q,    addr_d;
   logic [WORD_SIZE-1:0] wdata_q,   wdata_d;
   logic                 write_q,   write_d;
   logic                 i_ready_q, i_ready_d;
   logic                 d_ready_q, d_ready_d;
   logic [WORD_SIZE-1:0] i_data_q,  i_data_d;
   logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;

   logic                 pend_i, pend_d, grant_d, grant_i;

   // A port whose ready is high this cycle is masked so its held request
   // is not granted a second time.
   assign pend_i  = bus.i_req & ~i_ready_q;
   assign pend_d  = (bus.d_read | bus.d_write) & ~d_ready_q;
   // D has priority unless it had the previous grant and I is waiting.
   assign grant_d = pend_d & ~(last_d_q & pend_i);
   assign grant_i = pend_i & ~grant_d;

   // State register: all arbiter state, cleared asynchronously.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         last_d_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         i_data_q  <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_d_q  <= last_d_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         write_q   <= write_d;
         i_ready_q <= i_ready_d;
         d_ready_q <= d_ready_d;
         i_data_q  <= i_data_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // Next state: grant in IDLE, count down the access, complete at zero.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d_d  = last_d_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      i_ready_d = 1'b0;
      d_ready_d = 1'b0;
      i_data_d  = i_data_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (grant_d) begin
               state_d  = S_D_ACC;
               cnt_d    = CNT_LOAD;
               addr_d   = bus.d_addr;
               wdata_d  = bus.d_wdata;
               write_d  = bus.d_write;   // write wins when both are set
               last_d_d = 1'b1;
            end else if (grant_i) begin
               state_d  = S_I_ACC;
               cnt_d    = CNT_LOAD;
               addr_d   = bus.i_addr;
               wdata_d  = '0;
               write_d  = 1'b0;
               last_d_d = 1'b0;
            end
         end
         S_I_ACC: begin
            if (cnt_q == 4'd0) begin
               state_d   = S_IDLE;
               i_ready_d = 1'b1;
               i_data_d  = bus.mem_rdata;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_D_ACC: begin
            if (cnt_q == 4'd0) begin
               state_d   = S_IDLE;
               d_ready_d = 1'b1;
               if (!write_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: memory strobes come only from latched state, zero in IDLE.
   always_comb begin
      bus.busy      = (state_q != S_IDLE);
      bus.mem_read  = (state_q == S_I_ACC) | ((state_q == S_D_ACC) & ~write_q);
      bus.mem_write = (state_q == S_D_ACC) & write_q;
      bus.mem_addr  = (state_q != S_IDLE) ? addr_q  : '0;
      bus.mem_wdata = (state_q != S_IDLE) ? wdata_q : '0;
      bus.i_ready   = i_ready_q;
      bus.d_ready   = d_ready_q;
      bus.i_data    = i_data_q;
      bus.d_rdata   = d_rdata_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                         |
// | Description : Self-checking bench for mem_arbiter: directed cases    |
// |               plus randomized traffic against a timeline model.      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;
   localparam int W   = 16;
   localparam int LAT = 2;

   // {busy, mem_read, mem_write, mem_addr, mem_wdata, i_ready, d_ready, i_data, d_rdata}
   typedef logic [4*W+4:0] snap_t;

   logic clk = 1'b0;
   logic reset_n;
   int   nvec = 0;
   int   nerr = 0;

   mem_arbiter_if #(.WORD_SIZE(W)) bus ();

   mem_arbiter #(.WORD_SIZE(W), .LATENCY(LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Snapshot of all outputs; write data is only meaningful when writing.
   function automatic snap_t snap(input bit wmask);
      logic [W-1:0] wd;
      wd = wmask ? bus.mem_wdata : {W{1'b0}};
      return {bus.busy, bus.mem_read, bus.mem_write, bus.mem_addr, wd,
              bus.i_ready, bus.d_ready, bus.i_data, bus.d_rdata};
   endfunction

   task automatic clear_inputs();
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_rdata = '0;
   endtask

   // Leaves the bench #1 after a rising edge with reset just released (cycle 0).
   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b0;
   endtask

   task automatic test_reset();
      snap_t got;
      clear_inputs();
      reset_n = 1'b1;
      bus.i_req = 1'b1; bus.d_read = 1'b1; bus.d_addr = 16'h00AA; bus.mem_rdata = 16'hFFFF;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         got = snap(1'b1);
         nvec++;
         if (got !== '0) begin
            nerr++;
            $display("FAIL reset_outputs c%0d: got %h expected 0", c, got);
         end
      end
   endtask

   task automatic test_single_fetch();
      snap_t got, exp;
      bit acc;
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 16'h0010; bus.mem_rdata = 16'h1234;
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         acc = (c == 1 || c == 2);
         exp = {acc, acc, 1'b0, (acc ? 16'h0010 : 16'h0000), 16'h0000,
                (c == 3), 1'b0, (c >= 3 ? 16'h1234 : 16'h0000), 16'h0000};
         got = snap(1'b0);
         nvec++;
         if (got !== exp) begin
            nerr++;
            $display("FAIL single_fetch c%0d: got %h expected %h", c, got, exp);
         end
         if (c == 3) bus.i_req = 1'b0;
      end
   endtask

   task automatic test_dual_request();
      snap_t got, exp;
      bit dacc, iacc;
      logic [W-1:0] e_id, e_dd;
      do_reset();
      e_id = '0; e_dd = '0;
      bus.i_req = 1'b1; bus.i_addr = 16'h0040;
      bus.d_read = 1'b1; bus.d_addr = 16'h0080;
      for (int c = 0; c <= 7; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         bus.mem_rdata = 16'hA000 + 16'(c);
         dacc = (c == 1 || c == 2);
         iacc = (c == 4 || c == 5);
         if (c == 3) e_dd = 16'hA002;
         if (c == 6) e_id = 16'hA005;
         exp = {dacc | iacc, dacc | iacc, 1'b0,
                (dacc ? 16'h0080 : (iacc ? 16'h0040 : 16'h0000)), 16'h0000,
                (c == 6), (c == 3), e_id, e_dd};
         got = snap(1'b0);
         nvec++;
         if (got !== exp) begin
            nerr++;
            $display("FAIL dual_request c%0d: got %h expected %h", c, got, exp);
         end
         if (c == 3) bus.d_read = 1'b0;
         if (c == 6) bus.i_req  = 1'b0;
      end
   endtask

   // A read followed by a write queued during the read's ready cycle.
   task automatic test_write();
      snap_t got, exp;
      bit racc, wacc;
      do_reset();
      bus.d_read = 1'b1; bus.d_addr = 16'h0021; bus.mem_rdata = 16'hCAFE;
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         racc = (c == 1 || c == 2);
         wacc = (c == 5 || c == 6);
         exp = {racc | wacc, racc, wacc,
                (racc ? 16'h0021 : (wacc ? 16'h0020 : 16'h0000)),
                (wacc ? 16'hBEEF : 16'h0000),
                1'b0, (c == 3 || c == 7), 16'h0000,
                (c >= 3 ? 16'hCAFE : 16'h0000)};
         got = snap(wacc);
         nvec++;
         if (got !== exp) begin
            nerr++;
            $display("FAIL write c%0d: got %h expected %h", c, got, exp);
         end
         if (c == 3) begin
            bus.d_read = 1'b0; bus.d_write = 1'b1;
            bus.d_addr = 16'h0020; bus.d_wdata = 16'hBEEF; bus.mem_rdata = 16'h5555;
         end
         if (c == 7) bus.d_write = 1'b0;
      end
   endtask

   task automatic test_read_write_both();
      snap_t got, exp;
      bit acc;
      do_reset();
      bus.d_read = 1'b1; bus.d_write = 1'b1;
      bus.d_addr = 16'h0030; bus.d_wdata = 16'h1111; bus.mem_rdata = 16'h9999;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         acc = (c == 1 || c == 2);
         exp = {acc, 1'b0, acc, (acc ? 16'h0030 : 16'h0000), (acc ? 16'h1111 : 16'h0000),
                1'b0, (c == 3), 16'h0000, 16'h0000};
         got = snap(acc);
         nvec++;
         if (got !== exp) begin
            nerr++;
            $display("FAIL read_write_both c%0d: got %h expected %h", c, got, exp);
         end
         if (c == 3) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
      end
   endtask

   // Both requests held forever: grants alternate D, I, D, I, ...
   task automatic test_back_to_back();
      snap_t got, exp;
      int n, ph;
      bit isd, acc;
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 16'h00A0;
      bus.d_read = 1'b1; bus.d_addr = 16'h00D0; bus.mem_rdata = 16'h0000;
      for (int c = 1; c <= 5 * (LAT + 1); c++) begin
         @(posedge clk); #1;
         n   = (c - 1) / (LAT + 1);
         ph  = (c - 1) % (LAT + 1);
         isd = (n % 2 == 0);
         acc = (ph < LAT);
         exp = {acc, acc, 1'b0, (acc ? (isd ? 16'h00D0 : 16'h00A0) : 16'h0000), 16'h0000,
                (!acc && !isd), (!acc && isd), 16'h0000, 16'h0000};
         got = snap(1'b0);
         nvec++;
         if (got !== exp) begin
            nerr++;
            $display("FAIL back_to_back c%0d: got %h expected %h", c, got, exp);
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_access();
      snap_t got, exp;
      bit acc;
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 16'h0050; bus.mem_rdata = 16'h7777;
      @(posedge clk); #1;
      exp = {1'b1, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
      got = snap(1'b0);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL reset_mid_pre: got %h expected %h", got, exp);
      end
      #2 reset_n = 1'b1;
      #1;
      got = snap(1'b1);
      nvec++;
      if (got !== '0) begin
         nerr++;
         $display("FAIL reset_mid_async: got %h expected 0", got);
      end
      @(posedge clk); #1 reset_n = 1'b0;
      for (int c = 2; c <= 6; c++) begin
         if (c > 2) begin @(posedge clk); #1; end
         acc = (c == 3 || c == 4);
         exp = {acc, acc, 1'b0, (acc ? 16'h0050 : 16'h0000), 16'h0000,
                (c == 5), 1'b0, (c >= 5 ? 16'h7777 : 16'h0000), 16'h0000};
         got = snap(1'b0);
         nvec++;
         if (got !== exp) begin
            nerr++;
            $display("FAIL reset_mid_regrant c%0d: got %h expected %h", c, got, exp);
         end
         if (c == 5) bus.i_req = 1'b0;
      end
   endtask

   // Random traffic. The model keeps one grant as a timeline: decided in
   // cycle g, memory busy in g+1..g+LAT, ready in g+LAT+1 (an idle cycle).
   task automatic test_random(input int ncyc);
      snap_t got, exp;
      bit has_g, g_is_d, g_wr, last_d, e_busy, e_ir, e_dr, want_i, want_d, pick_d;
      int g_cyc, kind;
      logic [W-1:0] g_addr, g_wdata, cap, e_idata, e_drdata;
      do_reset();
      has_g = 1'b0; last_d = 1'b0; g_cyc = 0; g_is_d = 1'b0; g_wr = 1'b0;
      g_addr = '0; g_wdata = '0; cap = '0; e_idata = '0; e_drdata = '0;
      for (int k = 0; k < ncyc; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         e_busy = has_g && (k > g_cyc) && (k <= g_cyc + LAT);
         e_ir   = has_g && !g_is_d && (k == g_cyc + LAT + 1);
         e_dr   = has_g &&  g_is_d && (k == g_cyc + LAT + 1);
         if (e_ir) e_idata = cap;
         if (e_dr && !g_wr) e_drdata = cap;

         // clients: drop on completion, rarely abandon, otherwise maybe request
         if (e_ir) bus.i_req = 1'b0;
         else if (bus.i_req) begin
            if ($urandom_range(15) == 0) bus.i_req = 1'b0;
         end else if ($urandom_range(2) == 0) begin
            bus.i_req = 1'b1; bus.i_addr = W'($urandom);
         end
         if (e_dr) begin
            bus.d_read = 1'b0; bus.d_write = 1'b0;
         end else if (bus.d_read || bus.d_write) begin
            if ($urandom_range(15) == 0) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
         end else if ($urandom_range(2) == 0) begin
            kind = int'($urandom_range(2));
            bus.d_read  = (kind != 1);
            bus.d_write = (kind != 0);
            bus.d_addr  = W'($urandom);
            bus.d_wdata = W'($urandom);
         end
         bus.mem_rdata = W'($urandom);

         exp = {e_busy, e_busy && !g_wr, e_busy && g_wr,
                (e_busy ? g_addr : {W{1'b0}}),
                ((e_busy && g_wr) ? g_wdata : {W{1'b0}}),
                e_ir, e_dr, e_idata, e_drdata};
         got = snap(e_busy && g_wr);
         nvec++;
         if (got !== exp) begin
            nerr++;
            $display("FAIL random k%0d: got %h expected %h", k, got, exp);
         end

         if (has_g && k == g_cyc + LAT) cap = bus.mem_rdata;

         if (!has_g || k >= g_cyc + LAT + 1) begin
            want_i = bus.i_req && !e_ir;
            want_d = (bus.d_read || bus.d_write) && !e_dr;
            if (want_i || want_d) begin
               pick_d  = want_d && !(want_i && last_d);
               has_g   = 1'b1;
               g_cyc   = k;
               g_is_d  = pick_d;
               last_d  = pick_d;
               g_wr    = pick_d && bus.d_write;
               g_addr  = pick_d ? bus.d_addr : bus.i_addr;
               g_wdata = bus.d_wdata;
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      reset_n = 1'b1;
      test_reset();
      test_single_fetch();
      test_dual_request();
      test_write();
      test_read_write_both();
      test_back_to_back();
      test_reset_mid_access();
      test_random(600);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
